// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - serial PRBS stream and status bundle for prbs_checker
//
// Signals:
//   din        received serial PRBS bit
//   din_valid  qualifies din
//   clr_err    synchronous clear of err_cnt
//   locked     checker is in the LOCKED state
//   err_pulse  one-cycle pulse per bit error counted while locked
//   err_cnt    saturating 16-bit bit-error count
//
// Modports: master drives the stream and clr_err (source / host side),
//           slave is the checker.

interface prbs_checker_if;
    logic        din;
    logic        din_valid;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;

    modport master (
        output din,
        output din_valid,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  err_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        input  clr_err,
        output locked,
        output err_pulse,
        output err_cnt
    );
endinterface

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker with lock tracking and error counting
//
// Parameters:
//   N         LFSR length in bits (N >= 3)
//   TAPS      feedback mask over s[N-1:0]; expected bit = ^(TAPS & s)
//   LOCK_CNT  consecutive matches in SYNC needed to declare lock
//   LOSS_CNT  consecutive mismatches in LOCKED that drop back to HUNT
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_b  asynchronous active-low reset
//   bus    prbs_checker_if.slave: din/din_valid/clr_err in,
//          locked/err_pulse/err_cnt out (all outputs registered)

module prbs_checker #(
    parameter int             N        = 4,
    parameter logic [N-1:0]   TAPS     = 4'b1100,
    parameter int             LOCK_CNT = 8,
    parameter int             LOSS_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    prbs_checker_if.slave bus
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state,     state_n;
    logic [N-1:0]  s,         s_n;
    logic [FW-1:0] fill_cnt,  fill_cnt_n;
    logic [MW-1:0] match_cnt, match_cnt_n;
    logic [BW-1:0] bad_cnt,   bad_cnt_n;
    logic          locked_n;
    logic          err_pulse_n;
    logic [15:0]   err_cnt_n;
    logic [15:0]   err_base;
    logic          e;

    // Predicted next bit from the current register contents.
    assign e = ^(TAPS & s);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= HUNT;
            s             <= '1;
            fill_cnt      <= '0;
            match_cnt     <= '0;
            bad_cnt       <= '0;
            bus.locked    <= 1'b0;
            bus.err_pulse <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            state         <= state_n;
            s             <= s_n;
            fill_cnt      <= fill_cnt_n;
            match_cnt     <= match_cnt_n;
            bad_cnt       <= bad_cnt_n;
            bus.locked    <= locked_n;
            bus.err_pulse <= err_pulse_n;
            bus.err_cnt   <= err_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_n         = s;
        fill_cnt_n  = fill_cnt;
        match_cnt_n = match_cnt;
        bad_cnt_n   = bad_cnt;
        err_pulse_n = 1'b0;
        // clr_err applies every cycle; a same-cycle locked error counts on top of the cleared value.
        err_base    = bus.clr_err ? 16'd0 : bus.err_cnt;
        err_cnt_n   = err_base;

        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    s_n = {s[N-2:0], bus.din};
                    if (fill_cnt == FW'(N - 1)) begin
                        state_n     = SYNC;
                        fill_cnt_n  = '0;
                        match_cnt_n = '0;
                    end else begin
                        fill_cnt_n = fill_cnt + 1'b1;
                    end
                end

                SYNC: begin
                    // Received bits feed the register, so a wrong guess self-corrects after N bits.
                    s_n = {s[N-2:0], bus.din};
                    if ((bus.din != e) || (s_n == '0)) begin
                        match_cnt_n = '0;
                    end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                        state_n     = LOCKED;
                        match_cnt_n = '0;
                        bad_cnt_n   = '0;
                    end else begin
                        match_cnt_n = match_cnt + 1'b1;
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction so a single line error is not re-seen N times.
                    s_n = {s[N-2:0], e};
                    if (bus.din != e) begin
                        err_pulse_n = 1'b1;
                        if (err_base != 16'hFFFF) begin
                            err_cnt_n = err_base + 16'd1;
                        end
                        if (bad_cnt == BW'(LOSS_CNT - 1)) begin
                            state_n     = HUNT;
                            fill_cnt_n  = '0;
                            match_cnt_n = '0;
                            bad_cnt_n   = '0;
                        end else begin
                            bad_cnt_n = bad_cnt + 1'b1;
                        end
                    end else begin
                        bad_cnt_n = '0;
                    end
                end

                default: begin
                    state_n     = HUNT;
                    fill_cnt_n  = '0;
                    match_cnt_n = '0;
                    bad_cnt_n   = '0;
                end
            endcase
        end

        locked_n = (state_n == LOCKED);
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 4: LFSR length in bits (N >= 3).
REQ-002 Parameter TAPS, default 4'b1100: feedback mask over shift register s[N-1:0] (default = x^4+x^3+1, period 15).
REQ-003 Parameter LOCK_CNT, default 8: consecutive matches required to declare lock.
REQ-004 Parameter LOSS_CNT, default 4: consecutive mismatches while locked that force loss of lock.
REQ-005 clk  input  1  clock; all state changes on posedge clk.
REQ-006 rst_b  input  1  reset, asynchronous, active-low.
REQ-007 din  input  1  received serial PRBS bit.
REQ-008 din_valid  input  1  din qualifier; no state changes when low except clr_err.
REQ-009 clr_err  input  1  synchronous clear of err_cnt.
REQ-010 locked  output  1  high while in LOCKED state (registered).
REQ-011 err_pulse  output  1  one-cycle pulse per bit error detected in LOCKED (registered).
REQ-012 err_cnt  output  16  saturating count of bit errors detected in LOCKED.

Function
REQ-013 Expected bit e = XOR over i of (TAPS[i] & s[i]), evaluated on current s before update.
REQ-014 States: HUNT, SYNC, LOCKED; encoding is implementation choice; only locked is visible externally.
REQ-015 HUNT: each valid bit sets s <= {s[N-2:0], din}, fill_cnt++; after N valid bits -> SYNC with match_cnt = 0.
REQ-016 SYNC: each valid bit shifts din into s (self-synchronising); din == e -> match_cnt++; din != e -> match_cnt <= 0, stay SYNC.
REQ-017 SYNC: if updated s is all-zero, match_cnt <= 0 (no lock on all-zero stream).
REQ-018 SYNC -> LOCKED when the LOCK_CNT-th consecutive match is received with nonzero updated s; locked high from the next cycle.
REQ-019 LOCKED: each valid bit shifts e (not din) into s, so one line error yields exactly one counted error.
REQ-020 LOCKED mismatch: err_pulse high next cycle, err_cnt++ (saturate at 16'hFFFF), bad_cnt++; match: bad_cnt <= 0.
REQ-021 LOCKED -> HUNT on the LOSS_CNT-th consecutive mismatch; locked low next cycle; fill_cnt, match_cnt, bad_cnt <= 0; err_cnt retained.
REQ-022 err_pulse low in HUNT and SYNC; mismatches there never change err_cnt.
REQ-023 clr_err alone: err_cnt <= 0 next cycle regardless of din_valid or state.
REQ-024 clr_err with a simultaneous LOCKED mismatch: err_cnt <= 1; err_pulse still asserted.
REQ-025 din_valid low: s, counters, state hold; err_pulse low.
REQ-026 Counters fill_cnt, match_cnt, bad_cnt sized to their limits; no wrap-around.

Reset
REQ-027 rst_b low (any time, incl. mid-lock): state HUNT, s all ones, fill_cnt/match_cnt/bad_cnt = 0, locked = 0, err_pulse = 0, err_cnt = 0, immediately without clk.
REQ-028 After rst_b rises, first valid bit on the next posedge is treated as HUNT bit 1.

Verification
REQ-029 Clean default PRBS (x^4+x^3+1, seed 4'b1111), din_valid=1, 30 bits -> locked rises after bit 12 (4 fill + 8 matches), err_cnt stays 0.
REQ-030 Locked, invert one bit -> exactly one err_pulse, err_cnt = 1, locked stays 1.
REQ-031 Locked, invert 4 consecutive bits -> err_cnt = 4, locked falls after 4th; clean stream resumes -> relock after 12 further bits, err_cnt still 4.
REQ-032 All-zero stream, 40 bits -> locked never asserts, err_cnt = 0.
REQ-033 Locked with err_cnt = 3, assert clr_err same cycle as an error -> err_cnt = 1; clr_err alone next -> err_cnt = 0.
REQ-034 din_valid toggled every other cycle on clean stream -> lock after 12 valid bits; rst_b pulse while locked -> locked = 0, err_cnt = 0 asynchronously.
